// File: rtl/quadrature_decoder_pkg.sv
// quadrature_decoder_pkg: shared state encodings, direction constants, CW successor helper.
// Rev 1.0
`default_nettype none

package quadrature_decoder_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qstate_e;

    localparam logic CW  = 1'b1;
    localparam logic CCW = 1'b0;

    localparam int CNT_W = 8;

    // Successor of s when turning clockwise: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            S00:     n = S01;
            S01:     n = S11;
            S11:     n = S10;
            default: n = S00;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quadrature_decoder_debounce_filter.sv
// debounce_filter: accepts a synchronized level once it has differed from the filtered value for DEBOUNCE_CYCLES cycles.
// Rev 1.0
`default_nettype none

module debounce_filter
    import quadrature_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic filt_o
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_i != filt_q) begin
            if (cnt_q == C_LAST) begin
                filt_d = sync_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

`default_nettype wire

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronizes and debounces A/B, decodes x4 steps, counts detents.
// Rev 1.0
`default_nettype none

module quadrature_decoder
    import quadrature_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int POS_WIDTH       = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 A,
    input  logic                 B,
    output logic                 Step,
    output logic                 Dir,
    output logic                 Detent,
    output logic [POS_WIDTH-1:0] Position,
    output logic                 Error
);

    logic [1:0] meta_q, sync_q;
    logic [1:0] filt_w;
    logic [1:0] prev_q, prev_d;
    logic       armed_q, armed_d;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic       detent_q, detent_d;
    logic       error_q, error_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {A, B};
            sync_q <= meta_q;
        end
    end

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
        .clk_i  (Clk),
        .rst_ni (Reset_N),
        .sync_i (sync_q[1]),
        .filt_o (filt_w[1])
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
        .clk_i  (Clk),
        .rst_ni (Reset_N),
        .sync_i (sync_q[0]),
        .filt_o (filt_w[0])
    );

    always_comb begin
        prev_d   = prev_q;
        armed_d  = armed_q;
        step_d   = 1'b0;
        detent_d = 1'b0;
        error_d  = 1'b0;
        dir_d    = dir_q;
        pos_d    = pos_q;
        if (filt_w != prev_q) begin
            prev_d = filt_w;
            if (!armed_q) begin
                // First accepted state after reset is only a reference point.
                armed_d = 1'b1;
            end else if (filt_w == ~prev_q) begin
                error_d = 1'b1;
            end else begin
                step_d = 1'b1;
                dir_d  = (filt_w == cw_next(prev_q)) ? CW : CCW;
                if (filt_w == S00) begin
                    detent_d = 1'b1;
                    pos_d    = (dir_d == CW) ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            prev_q   <= S00;
            armed_q  <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            detent_q <= 1'b0;
            error_q  <= 1'b0;
            pos_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            detent_q <= detent_d;
            error_q  <= error_d;
            pos_q    <= pos_d;
        end
    end

    assign Step     = step_q;
    assign Dir      = dir_q;
    assign Detent   = detent_q;
    assign Error    = error_q;
    assign Position = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed scenarios with hand-computed expectations.
// Rev 1.0
`default_nettype none

module tb_quadrature_decoder;

    logic       Clk = 1'b0;
    logic       Reset_N = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       Step, Dir, Detent, Error;
    logic [7:0] Position;

    int checks = 0;
    int errors = 0;

    int step_cnt = 0, detent_cnt = 0, error_cnt = 0, dbl_cnt = 0;
    logic prev_pulse = 1'b0;

    quadrature_decoder #(.DEBOUNCE_CYCLES(4), .POS_WIDTH(8)) dut (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .A        (A),
        .B        (B),
        .Step     (Step),
        .Dir      (Dir),
        .Detent   (Detent),
        .Position (Position),
        .Error    (Error)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Step)   step_cnt++;
        if (Detent) detent_cnt++;
        if (Error)  error_cnt++;
        if ((Step || Detent || Error) && prev_pulse) dbl_cnt++;
        prev_pulse = Step || Detent || Error;
    end

    task automatic set_ab(input logic a, input logic b, input int hold);
        @(negedge Clk);
        A = a;
        B = b;
        repeat (hold) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_N = 1'b0;
        A = 1'b0;
        B = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_N = 1'b1;
    endtask

    // Arm at 11, then jump to 00 (an illegal double change) so the decoder sits armed at 00 with Position 0.
    task automatic arm_at_00();
        int e0;
        set_ab(1, 1, 10);
        e0 = error_cnt;
        set_ab(0, 0, 10);
        checks++;
        if (error_cnt - e0 !== 1 || Position !== 8'd0) begin
            errors++;
            $display("FAIL arm_at_00: errors=%0d pos=%0d, required errors=1 pos=0", error_cnt - e0, Position);
        end
    endtask

    task automatic cw_cycle();
        set_ab(0, 1, 8); set_ab(1, 1, 8); set_ab(1, 0, 8); set_ab(0, 0, 8);
    endtask

    task automatic ccw_cycle();
        set_ab(1, 0, 8); set_ab(1, 1, 8); set_ab(0, 1, 8); set_ab(0, 0, 8);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({Step, Dir, Detent, Error} !== 4'b0000 || Position !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got step=%b dir=%b det=%b err=%b pos=%0d, required all 0",
                     Step, Dir, Detent, Error, Position);
        end
        Reset_N = 1'b1;
    endtask

    task automatic test_arm_cw();
        int s0, e0, d0;
        s0 = step_cnt; e0 = error_cnt;
        set_ab(1, 1, 10);
        checks++;
        if (step_cnt - s0 !== 0 || error_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL arm_only: steps=%0d errors=%0d, required 0 0", step_cnt - s0, error_cnt - e0);
        end
        s0 = step_cnt; d0 = detent_cnt;
        set_ab(1, 0, 10);
        checks++;
        if (step_cnt - s0 !== 1 || Dir !== 1'b1 || detent_cnt - d0 !== 0 || Position !== 8'd0) begin
            errors++;
            $display("FAIL one_cw_step: steps=%0d dir=%b detents=%0d pos=%0d, required 1 1 0 0",
                     step_cnt - s0, Dir, detent_cnt - d0, Position);
        end
    endtask

    task automatic test_cw_detents();
        int s0, d0, e0;
        do_reset();
        arm_at_00();
        s0 = step_cnt; d0 = detent_cnt; e0 = error_cnt;
        for (int i = 0; i < 4; i++) cw_cycle();
        checks++;
        if (step_cnt - s0 !== 16 || detent_cnt - d0 !== 4 || Position !== 8'd4 || Dir !== 1'b1 || error_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL four_cw: steps=%0d detents=%0d pos=%0d dir=%b errors=%0d, required 16 4 4 1 0",
                     step_cnt - s0, detent_cnt - d0, Position, Dir, error_cnt - e0);
        end
        ccw_cycle();
        checks++;
        if (Position !== 8'd3 || Dir !== 1'b0) begin
            errors++;
            $display("FAIL one_ccw: pos=%0d dir=%b, required 3 0", Position, Dir);
        end
        checks++;
        if (dbl_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_width: consecutive pulse cycles=%0d, required 0", dbl_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        arm_at_00();
        ccw_cycle();
        checks++;
        if (Position !== 8'd255 || Dir !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down: pos=%0d dir=%b, required 255 0", Position, Dir);
        end
        cw_cycle();
        checks++;
        if (Position !== 8'd0 || Dir !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up: pos=%0d dir=%b, required 0 1", Position, Dir);
        end
    endtask

    task automatic test_glitch_timing();
        int s0;
        logic [7:0] seen;
        s0 = step_cnt;
        set_ab(1, 0, 3);
        A = 1'b0;
        repeat (10) @(negedge Clk);
        checks++;
        if (step_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL glitch_3cyc: steps=%0d, required 0", step_cnt - s0);
        end
        A = 1'b1;
        seen = '0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge Clk);
            seen[i] = Step;
        end
        checks++;
        if (seen[6:1] !== 6'b0 || seen[7] !== 1'b1) begin
            errors++;
            $display("FAIL step_latency: step by edge[7:1]=%b, required 1000000", seen[7:1]);
        end
        @(negedge Clk);
        checks++;
        if (Step !== 1'b0 || Dir !== 1'b0 || Position !== 8'd0) begin
            errors++;
            $display("FAIL after_step: step=%b dir=%b pos=%0d, required 0 0 0", Step, Dir, Position);
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_error();
        int s0, e0, d0;
        set_ab(0, 0, 10);
        checks++;
        if (Position !== 8'd1 || Dir !== 1'b1) begin
            errors++;
            $display("FAIL back_to_00: pos=%0d dir=%b, required 1 1", Position, Dir);
        end
        s0 = step_cnt; e0 = error_cnt; d0 = detent_cnt;
        set_ab(1, 1, 10);
        checks++;
        if (error_cnt - e0 !== 1 || step_cnt - s0 !== 0 || detent_cnt - d0 !== 0 || Position !== 8'd1 || Dir !== 1'b1) begin
            errors++;
            $display("FAIL double_change: errors=%0d steps=%0d detents=%0d pos=%0d dir=%b, required 1 0 0 1 1",
                     error_cnt - e0, step_cnt - s0, detent_cnt - d0, Position, Dir);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int s0, e0, d0;
        @(negedge Clk);
        A = 1'b0;
        repeat (4) @(negedge Clk);
        #2;
        Reset_N = 1'b0;
        #1;
        checks++;
        if ({Step, Dir, Detent, Error} !== 4'b0000 || Position !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: step=%b dir=%b det=%b err=%b pos=%0d, required all 0",
                     Step, Dir, Detent, Error, Position);
        end
        repeat (3) @(negedge Clk);
        s0 = step_cnt; e0 = error_cnt; d0 = detent_cnt;
        Reset_N = 1'b1;
        repeat (12) @(negedge Clk);
        checks++;
        if (step_cnt - s0 !== 0 || error_cnt - e0 !== 0 || detent_cnt - d0 !== 0 || Position !== 8'd0) begin
            errors++;
            $display("FAIL rearm_only: steps=%0d errors=%0d detents=%0d pos=%0d, required 0 0 0 0",
                     step_cnt - s0, error_cnt - e0, detent_cnt - d0, Position);
        end
        s0 = step_cnt;
        set_ab(0, 0, 10);
        checks++;
        if (step_cnt - s0 !== 1 || Position !== 8'd255 || Dir !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_step: steps=%0d pos=%0d dir=%b, required 1 255 0",
                     step_cnt - s0, Position, Dir);
        end
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        test_reset();
        test_arm_cw();
        test_cw_detents();
        test_wrap();
        test_glitch_timing();
        test_error();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles (range 1..255) a synchronized input must hold before being accepted.
REQ-002 Parameter POS_WIDTH, default 8, width of the detent position counter.
REQ-003 Clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset_N  input  1  asynchronous, active-low reset.
REQ-005 A  input  1  raw rotary channel A, asynchronous to Clk, bouncy.
REQ-006 B  input  1  raw rotary channel B, asynchronous to Clk, bouncy.
REQ-007 Step  output  1  one-cycle pulse per valid x4 quadrature transition.
REQ-008 Dir  output  1  direction of the most recent valid transition: 1 = CW, 0 = CCW.
REQ-009 Detent  output  1  one-cycle pulse when a valid transition lands in state AB=00.
REQ-010 Position  output  POS_WIDTH  detent count, two's-complement, modulo 2^POS_WIDTH.
REQ-011 Error  output  1  one-cycle pulse on an illegal transition (both channels changed together).

Function
REQ-012 A and B SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL have an independent debounce counter, cleared whenever the synchronized value equals the filtered value.
REQ-014 A filtered value SHALL take the synchronized value on the edge where its channel has differed for DEBOUNCE_CYCLES consecutive cycles; a shorter glitch SHALL change nothing.
REQ-015 A clean raw edge held stable SHALL produce Step exactly DEBOUNCE_CYCLES+3 Clk edges after the first sampling edge: 2 synchronizer, DEBOUNCE_CYCLES filter, 1 decode register.
REQ-016 Decoder SHALL compare filtered {A,B} against a registered previous state every cycle.
REQ-017 CW sequence SHALL be 00->01->11->10->00; the reverse sequence is CCW.
REQ-018 A single-bit change SHALL pulse Step for one cycle and set Dir; Dir SHALL hold otherwise.
REQ-019 A two-bit change SHALL pulse Error, SHALL NOT pulse Step or Detent, SHALL NOT alter Dir or Position, and SHALL load the new state as previous.
REQ-020 A valid transition into 00 SHALL pulse Detent in the same cycle as Step.
REQ-021 Position SHALL increment on each CW Detent and decrement on each CCW Detent, wrapping 2^POS_WIDTH-1 -> 0 and 0 -> 2^POS_WIDTH-1.
REQ-022 Step, Detent and Error SHALL be registered, never high for two consecutive cycles from one transition.
REQ-023 Decoder SHALL be unarmed after reset; the first filtered-state update SHALL only load the previous state and arm the decoder, with no Step, Detent or Error.
REQ-024 Equal filtered and previous state SHALL produce no pulse.

Reset
REQ-025 Reset_N low SHALL asynchronously clear synchronizers, debounce counters, filtered state (00), previous state (00), the armed flag, Step, Dir, Detent, Error and Position (all 0).
REQ-026 Reset asserted mid-debounce or mid-pulse SHALL abort it with no residual pulse after release.
REQ-027 Reset_N release SHALL take effect synchronously to Clk (release synchronized externally).

Structure
REQ-028 Shared package SHALL hold the 2-bit state encodings (S00, S01, S11, S10) and direction constants CW=1, CCW=0.
REQ-029 The debounce filter SHALL be a sub-module, debounce_filter, instantiated once per channel; synchronizer, decoder and position counter stay in quadrature_decoder.

Verification
REQ-030 Reset, arm with AB=11, one CW step 11->10 held 10 cycles -> exactly 1 Step, Dir=1, no Detent, Position=0.
REQ-031 Four full CW detent cycles from 00 -> 16 Steps, 4 Detents, Position=4; then one CCW cycle -> Position=3, Dir=0.
REQ-032 Position=0, one CCW detent cycle -> Position=2^POS_WIDTH-1 (255 at default); one CW cycle -> 0.
REQ-033 With DEBOUNCE_CYCLES=4, A pulsed high for 3 cycles -> no filtered change and no Step; held for 6 cycles -> Step exactly 7 edges after first sample.
REQ-034 Armed at 00, A and B toggled on the same edge, both held -> one Error pulse, no Step, Position and Dir unchanged.
REQ-035 Reset_N asserted 2 cycles into a debounce window -> all outputs 0 immediately; after release the first accepted change only arms.
